// File: rtl/crpii_camera_pkg.sv
// Shared camera definitions: frame FSM state encoding and the default frame geometry
// used by the sensor emulator, the capture path and the benches.
package crpii_camera_pkg;

  localparam int unsigned DefaultPixelWidth    = 12;
  localparam int unsigned DefaultClkDiv        = 8;
  localparam int unsigned DefaultPixelsPerLine = 40;
  localparam int unsigned DefaultLines         = 5;
  localparam int unsigned DefaultFvToLv        = 3;
  localparam int unsigned DefaultLineGap       = 9;
  localparam int unsigned DefaultLvToFvEnd     = 15;
  localparam int unsigned DefaultFrameGap      = 36;
  localparam int unsigned DefaultPixelStep     = 16;

  // Width of the per-segment tick counter and the line counter.
  localparam int unsigned TickCntWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StLead,
    StLine,
    StBlank,
    StTail
  } cam_state_e;

endpackage

// File: rtl/pixel_clock_divider.sv
// Pixel clock generator for the camera emulator.
//   clk, reset   : system clock, synchronous active-high reset
//   pixel_clock  : low for the first CLK_DIV/2 counts of each period, high for the rest
//   tick         : strobe on the cycle whose closing edge wraps the counter to 0, i.e. the
//                  edge on which pixel_clock falls; sensor outputs update on that edge
module pixel_clock_divider #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_clock,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] d_q, d_d;
  logic            pclk_q, pclk_d;
  logic            last;

  always_comb begin
    last   = (d_q == CntW'(CLK_DIV - 1));
    d_d    = last ? '0 : d_q + 1'b1;
    // Registered so the pin is a clean flop output rather than a compare.
    pclk_d = (d_d >= CntW'(CLK_DIV / 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= '0;
      pclk_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      pclk_q <= pclk_d;
    end
  end

  assign pixel_clock = pclk_q;
  assign tick        = last;

endmodule

// File: rtl/camera_frame_emulator.sv
// Camera sensor stand-in: drives pixel clock, FV, LV and a ramp pixel bus with
// programmable frame geometry and blanking.
//   clk, reset          : system clock, synchronous active-high reset
//   free_run            : level, frames repeat with FRAME_GAP ticks between them
//   trigger             : single-cycle pulse, starts one frame from idle
//   camera_pixel_clock  : divided pixel clock
//   camera_FV/LV        : frame / line valid, change only on pixel-clock falling edges
//   camera_pixel_out    : pixel data, ramps by PIXEL_STEP every tick while FV is high
//   busy                : frame accepted and FV not yet fallen
//   frame_done          : one-cycle pulse with FV fall
//   frame_count         : completed frames, wrapping
module camera_frame_emulator
  import crpii_camera_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH     = DefaultPixelWidth,
  parameter int unsigned CLK_DIV         = DefaultClkDiv,
  parameter int unsigned PIXELS_PER_LINE = DefaultPixelsPerLine,
  parameter int unsigned LINES           = DefaultLines,
  parameter int unsigned FV_TO_LV        = DefaultFvToLv,
  parameter int unsigned LINE_GAP        = DefaultLineGap,
  parameter int unsigned LV_TO_FV_END    = DefaultLvToFvEnd,
  parameter int unsigned FRAME_GAP       = DefaultFrameGap,
  parameter int unsigned PIXEL_STEP      = DefaultPixelStep
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   free_run,
  input  logic                   trigger,
  output logic                   camera_pixel_clock,
  output logic                   camera_FV,
  output logic                   camera_LV,
  output logic [PIXEL_WIDTH-1:0] camera_pixel_out,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);

  localparam logic [PIXEL_WIDTH-1:0]  Step     = PIXEL_WIDTH'(PIXEL_STEP);
  localparam logic [TickCntWidth-1:0] FvToLv   = TickCntWidth'(FV_TO_LV);
  localparam logic [TickCntWidth-1:0] LineLen  = TickCntWidth'(PIXELS_PER_LINE);
  localparam logic [TickCntWidth-1:0] LineGap  = TickCntWidth'(LINE_GAP);
  localparam logic [TickCntWidth-1:0] TailLen  = TickCntWidth'(LV_TO_FV_END);
  localparam logic [TickCntWidth-1:0] FrameGap = TickCntWidth'(FRAME_GAP);
  localparam logic [TickCntWidth-1:0] LastLine = TickCntWidth'(LINES - 1);

  logic tick;

  pixel_clock_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .pixel_clock(camera_pixel_clock),
    .tick       (tick)
  );

  cam_state_e              state_q, state_d;
  // Ticks already spent in the current segment, counting the tick that entered it.
  logic [TickCntWidth-1:0] cnt_q, cnt_d;
  logic [TickCntWidth-1:0] line_q, line_d;
  logic                    fv_q, fv_d;
  logic                    lv_q, lv_d;
  logic [PIXEL_WIDTH-1:0]  pix_q, pix_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             count_q, count_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    fv_d    = fv_q;
    lv_d    = lv_q;
    pix_d   = pix_q;
    done_d  = 1'b0;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        // Accepted immediately so busy rises at once; FV waits for the next tick in StLead.
        if (trigger || free_run) begin
          state_d = StLead;
        end
      end
      StGap: begin
        if (tick) begin
          if (cnt_q == FrameGap) begin
            if (free_run) begin
              state_d = StLead;
              fv_d    = 1'b1;
              pix_d   = '0;
              cnt_d   = 16'd1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StLead: begin
        if (tick) begin
          if (!fv_q) begin
            fv_d  = 1'b1;
            pix_d = '0;
            cnt_d = 16'd1;
          end else if (cnt_q == FvToLv) begin
            state_d = StLine;
            lv_d    = 1'b1;
            cnt_d   = 16'd1;
            line_d  = '0;
            pix_d   = pix_q + Step;
          end else begin
            cnt_d = cnt_q + 16'd1;
            pix_d = pix_q + Step;
          end
        end
      end
      StLine: begin
        if (tick) begin
          pix_d = pix_q + Step;
          if (cnt_q == LineLen) begin
            lv_d  = 1'b0;
            cnt_d = 16'd1;
            if (line_q == LastLine) begin
              state_d = StTail;
            end else begin
              state_d = StBlank;
              line_d  = line_q + 16'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StBlank: begin
        if (tick) begin
          pix_d = pix_q + Step;
          if (cnt_q == LineGap) begin
            state_d = StLine;
            lv_d    = 1'b1;
            cnt_d   = 16'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StTail: begin
        if (tick) begin
          if (cnt_q == TailLen) begin
            fv_d    = 1'b0;
            pix_d   = '0;
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
            cnt_d   = 16'd1;
            state_d = free_run ? StGap : StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
            pix_d = pix_q + Step;
          end
        end
      end
      default: begin
        state_d = StIdle;
        fv_d    = 1'b0;
        lv_d    = 1'b0;
        pix_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle) && (state_d != StGap);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      pix_q   <= pix_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign camera_FV        = fv_q;
  assign camera_LV        = lv_q;
  assign camera_pixel_out = pix_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign frame_count      = count_q;

endmodule
